// File: rtl/snake_move_ctrl.sv
// Snake game head controller: IDLE/RUN/OVER FSM, periodic move ticks,
// buffered direction input, wall detection, food scoring and body shift strobe.
module snake_move_ctrl #(
  parameter int TICK_DIV  = 5000000,
  parameter int STEP      = 20,
  parameter int X_MAX     = 620,
  parameter int Y_MAX     = 460,
  parameter int START_X   = 320,
  parameter int START_Y   = 240,
  parameter int MAX_SCORE = 63
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        food_hit,
  input  logic        self_hit,
  output logic [11:0] head_x,
  output logic [11:0] head_y,
  output logic        move_signal,
  output logic [7:0]  score,
  output logic        game_over,
  output logic [1:0]  state
);

  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;
  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

  state_t        cur;
  dir_t          dir;
  dir_t          pend_dir;
  dir_t          next_dir;
  dir_t          req_dir;
  logic          req_valid;
  logic [CW-1:0] tick_cnt;
  logic          food_latch;
  logic          tick;
  logic          wall;
  logic          idle_load;
  logic          scored;
  logic [11:0]   nx;
  logic [11:0]   ny;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  // Button request is checked against the committed dir so a tick can never reverse the snake.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = RIGHT;
    if (btn_up)         req_dir = UP;
    else if (btn_down)  req_dir = DOWN;
    else if (btn_left)  req_dir = LEFT;
    else if (btn_right) req_dir = RIGHT;
    else                req_valid = 1'b0;
    next_dir = (req_valid && req_dir != opposite(dir)) ? req_dir : pend_dir;
  end

  always_comb begin
    nx   = head_x;
    ny   = head_y;
    wall = 1'b0;
    case (next_dir)
      UP: begin
        wall = {1'b0, head_y} < 13'(STEP);
        ny   = head_y - 12'(STEP);
      end
      DOWN: begin
        wall = ({1'b0, head_y} + 13'(STEP)) > 13'(Y_MAX);
        ny   = head_y + 12'(STEP);
      end
      LEFT: begin
        wall = {1'b0, head_x} < 13'(STEP);
        nx   = head_x - 12'(STEP);
      end
      default: begin
        wall = ({1'b0, head_x} + 13'(STEP)) > 13'(X_MAX);
        nx   = head_x + 12'(STEP);
      end
    endcase
  end

  assign tick      = (cur == RUN) && (tick_cnt == CW'(TICK_DIV - 1));
  assign idle_load = reset || (cur == IDLE) || (cur == OVER && start);
  assign scored    = food_latch || food_hit;
  assign game_over = (cur == OVER);
  assign state     = cur;

  always_ff @(posedge CLOCK_50) begin
    move_signal <= 1'b0;
    if (idle_load) begin
      head_x     <= 12'(START_X);
      head_y     <= 12'(START_Y);
      score      <= 8'd0;
      dir        <= RIGHT;
      pend_dir   <= RIGHT;
      tick_cnt   <= '0;
      food_latch <= 1'b0;
    end else if (cur == RUN && !self_hit) begin
      pend_dir <= next_dir;
      if (!tick) begin
        tick_cnt   <= tick_cnt + 1'b1;
        food_latch <= scored;
      end else begin
        tick_cnt <= '0;
        dir      <= next_dir;
        if (!wall) begin
          head_x      <= nx;
          head_y      <= ny;
          move_signal <= 1'b1;
          food_latch  <= 1'b0;
          if (scored && score < 8'(MAX_SCORE))
            score <= score + 1'b1;
        end
      end
    end

    // Reset wins over every other condition in the same cycle.
    if (reset)
      cur <= IDLE;
    else begin
      case (cur)
        IDLE:    if (start) cur <= RUN;
        RUN:     if (self_hit || (tick && wall)) cur <= OVER;
        OVER:    if (start) cur <= IDLE;
        default: cur <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Self-checking bench for snake_move_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural game model.
module tb_snake_move_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int STEP      = 20;
  localparam int X_MAX     = 620;
  localparam int Y_MAX     = 460;
  localparam int START_X   = 320;
  localparam int START_Y   = 240;
  localparam int MAX_SCORE = 63;

  logic        clk;
  logic        reset, start, btn_up, btn_down, btn_left, btn_right, food_hit, self_hit;
  logic [11:0] head_x, head_y;
  logic        move_signal, game_over;
  logic [7:0]  score;
  logic [1:0]  state;

  int tests;
  int failures;

  // Behavioural model: position as plain integers, direction as a unit vector,
  // phase counts cycles spent in RUN since the last move step.
  int m_state, m_x, m_y, m_dx, m_dy, p_dx, p_dy, m_phase, m_score;
  bit m_food, m_move;

  snake_move_ctrl #(
    .TICK_DIV(TICK_DIV), .STEP(STEP), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .START_X(START_X), .START_Y(START_Y), .MAX_SCORE(MAX_SCORE)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .food_hit(food_hit), .self_hit(self_hit),
    .head_x(head_x), .head_y(head_y), .move_signal(move_signal),
    .score(score), .game_over(game_over), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic modelIdle();
    m_state = 0; m_x = START_X; m_y = START_Y;
    m_dx = 1; m_dy = 0; p_dx = 1; p_dy = 0;
    m_phase = 0; m_score = 0; m_food = 0; m_move = 0;
  endtask

  task automatic modelStep(input bit r, input bit s, input bit u, input bit d,
                           input bit l, input bit rt, input bit f, input bit sh);
    int bx, by, nx, ny;
    bit req;
    m_move = 0;
    if (r) modelIdle();
    else if (m_state == 0) begin
      modelIdle();
      if (s) m_state = 1;
    end else if (m_state == 2) begin
      if (s) modelIdle();
    end else if (sh) begin
      m_state = 2;
    end else begin
      req = 1; bx = 0; by = 0;
      if (u)       by = -1;
      else if (d)  by = 1;
      else if (l)  bx = -1;
      else if (rt) bx = 1;
      else         req = 0;
      if (req && !(bx == -m_dx && by == -m_dy)) begin
        p_dx = bx; p_dy = by;
      end
      m_food = m_food | f;
      if (m_phase == TICK_DIV - 1) begin
        m_phase = 0;
        m_dx = p_dx; m_dy = p_dy;
        nx = m_x + STEP * m_dx;
        ny = m_y + STEP * m_dy;
        if (nx < 0 || nx > X_MAX || ny < 0 || ny > Y_MAX) m_state = 2;
        else begin
          m_x = nx; m_y = ny; m_move = 1;
          if (m_food) begin
            m_score = (m_score + 1 > MAX_SCORE) ? MAX_SCORE : m_score + 1;
            m_food = 0;
          end
        end
      end else m_phase++;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit u, input bit d,
                               input bit l, input bit rt, input bit f, input bit sh);
    reset = r; start = s; btn_up = u; btn_down = d; btn_left = l; btn_right = rt;
    food_hit = f; self_hit = sh;
    modelStep(r, s, u, d, l, rt, f, sh);
    @(posedge clk);
    #1;
    checkOutput("head_x", int'(head_x), m_x);
    checkOutput("head_y", int'(head_y), m_y);
    checkOutput("move_signal", int'(move_signal), int'(m_move));
    checkOutput("score", int'(score), m_score);
    checkOutput("state", int'(state), m_state);
    checkOutput("game_over", int'(game_over), int'(m_state == 2));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pressDir(input int k, input bit f);
    case (k % 4)
      0: applyStimulus(0, 0, 0, 0, 0, 1, f, 0);
      1: applyStimulus(0, 0, 0, 1, 0, 0, f, 0);
      2: applyStimulus(0, 0, 0, 0, 1, 0, f, 0);
      default: applyStimulus(0, 0, 1, 0, 0, 0, f, 0);
    endcase
  endtask

  initial begin
    int hx, hy, b;
    bit r, s, f, sh, u, d, l, rt;
    tests = 0; failures = 0;
    reset = 1; start = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    food_hit = 0; self_hit = 0;
    modelIdle();

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_x", int'(head_x), 320);
    checkOutput("rst_y", int'(head_y), 240);

    // First move four cycles after start, then every four cycles.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("run_entry", int'(state), 1);
    idleCycles(3);
    checkOutput("pre_tick_x", int'(head_x), 320);
    checkOutput("pre_tick_mv", int'(move_signal), 0);
    idleCycles(1);
    checkOutput("tick1_x", int'(head_x), 340);
    checkOutput("tick1_y", int'(head_y), 240);
    checkOutput("tick1_mv", int'(move_signal), 1);
    idleCycles(1);
    checkOutput("mv_one_cycle", int'(move_signal), 0);
    idleCycles(3);
    checkOutput("tick2_x", int'(head_x), 360);
    checkOutput("tick2_mv", int'(move_signal), 1);

    // Reverse request ignored, perpendicular one taken.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    idleCycles(2);
    checkOutput("turn_up_y", int'(head_y), 220);
    checkOutput("turn_up_x", int'(head_x), 360);

    // Food mid-interval, then food on the tick cycle itself.
    idleCycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    idleCycles(2);
    checkOutput("score1", int'(score), 1);
    idleCycles(3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("score2", int'(score), 2);

    // Walk a small square eating every step until saturation.
    for (int k = 0; k < 61; k++) begin
      pressDir(k, 1);
      idleCycles(3);
    end
    checkOutput("score_max", int'(score), 63);
    pressDir(61, 1);
    idleCycles(3);
    checkOutput("score_sat", int'(score), 63);

    // self_hit on the tick cycle.
    idleCycles(3);
    hx = m_x; hy = m_y;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("self_state", int'(state), 2);
    checkOutput("self_go", int'(game_over), 1);
    checkOutput("self_mv", int'(move_signal), 0);
    checkOutput("self_x", int'(head_x), hx);
    checkOutput("self_y", int'(head_y), hy);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("over_frozen", int'(score), 63);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("restart_state", int'(state), 0);
    checkOutput("restart_x", int'(head_x), 320);
    checkOutput("restart_score", int'(score), 0);

    // Left wall from head_x=0.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    idleCycles(3);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    idleCycles(3);
    checkOutput("left_x300", int'(head_x), 300);
    idleCycles(4 * 15);
    checkOutput("left_x0", int'(head_x), 0);
    idleCycles(4);
    checkOutput("wall_state", int'(state), 2);
    checkOutput("wall_go", int'(game_over), 1);
    checkOutput("wall_x", int'(head_x), 0);
    checkOutput("wall_mv", int'(move_signal), 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("wall_idle_x", int'(head_x), 320);
    checkOutput("wall_idle_y", int'(head_y), 240);

    // Reset mid-count with score 5.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      idleCycles(3);
    end
    checkOutput("score5", int'(score), 5);
    idleCycles(2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midrst_state", int'(state), 0);
    checkOutput("midrst_score", int'(score), 0);
    checkOutput("midrst_x", int'(head_x), 320);
    checkOutput("midrst_mv", int'(move_signal), 0);

    // Reset beats start and self_hit on a tick cycle.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    idleCycles(3);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    checkOutput("rst_dom_state", int'(state), 0);
    checkOutput("rst_dom_x", int'(head_x), 320);

    // Randomized play; buttons held off on move cycles.
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      s  = ($urandom_range(0, 9) == 0);
      f  = ($urandom_range(0, 7) == 0);
      sh = ($urandom_range(0, 59) == 0);
      u = 0; d = 0; l = 0; rt = 0;
      b = $urandom_range(0, 7);
      if (!(m_state == 1 && m_phase == TICK_DIV - 1)) begin
        case (b)
          0: u = 1;
          1: d = 1;
          2: l = 1;
          3: rt = 1;
          default: ;
        endcase
      end
      applyStimulus(r, s, u, d, l, rt, f, sh);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
